id_issue_stage: RTL

- Decode/issue stage of the 5-stage MIPS pipeline.
- Accepts fetched instructions and reads the 32x32 register file, which this block owns; the writeback port feeds the file.
- Each cycle, registers the instruction, operand A (rf[rs]), operand B (rf[rt]), destination register and control bits toward the ALU/EX stage.
- Detects load-use hazards and inserts bubbles; honours branch flush.

---
 rtl/id_issue_stage.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/id_issue_stage.sv
// id_issue_stage: decode/issue stage of a 5-stage MIPS pipeline.
// Owns the 32x32 register file (write-through bypass from the writeback port),
// decodes the fetched word into an EX-bound bundle, inserts a one-cycle bubble
// on load-use hazards and honours branch flush and downstream backpressure.
// Optional build macro: ID_ILLEGAL_TRAP_EN adds out_illegal and replaces
// unsupported instructions with a NOP bundle flagged as illegal.
`timescale 1ns/1ps
module id_issue_stage #(
  parameter int          RF_DEPTH = 32,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000,
  localparam int         AW       = $clog2(RF_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_instr,
  input  logic          flush,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [31:0]   wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instr,
  output logic [31:0]   out_op_a,
  output logic [31:0]   out_op_b,
  output logic [AW-1:0] out_dest,
  output logic          out_reg_write,
  output logic          out_mem_read,
  output logic          out_mem_write,
  output logic          out_branch
`ifdef ID_ILLEGAL_TRAP_EN
  ,
  output logic          out_illegal
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;

  logic [31:0]   rf_q [RF_DEPTH];
  logic [31:0]   rf_d [RF_DEPTH];

  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic [AW-1:0] rs;
  logic [AW-1:0] rt;
  logic [AW-1:0] rd;

  logic [AW-1:0] dec_dest;
  logic          dec_reg_write;
  logic          dec_mem_read;
  logic          dec_mem_write;
  logic          dec_branch;
  logic          uses_rs;
  logic          uses_rt;

  logic [31:0]   op_a_rd;
  logic [31:0]   op_b_rd;

  logic          src_match;
  logic          hazard;
  logic          stall;

  logic          out_valid_q,     out_valid_d;
  logic [31:0]   out_instr_q,     out_instr_d;
  logic [31:0]   out_op_a_q,      out_op_a_d;
  logic [31:0]   out_op_b_q,      out_op_b_d;
  logic [AW-1:0] out_dest_q,      out_dest_d;
  logic          out_reg_write_q, out_reg_write_d;
  logic          out_mem_read_q,  out_mem_read_d;
  logic          out_mem_write_q, out_mem_write_d;
  logic          out_branch_q,    out_branch_d;
`ifdef ID_ILLEGAL_TRAP_EN
  logic          dec_legal;
  logic          out_illegal_q,   out_illegal_d;
`endif

  assign opcode = in_instr[31:26];
  assign rs     = in_instr[25:21];
  assign rt     = in_instr[20:16];
  assign rd     = in_instr[15:11];
  assign funct  = in_instr[5:0];

  // Register file next state: writeback lands on the edge, index 0 stays zero.
  always_comb begin
    rf_d = rf_q;
    if (wb_en && (wb_addr != '0)) begin
      rf_d[wb_addr] = wb_data;
    end
  end

  // Register file storage, cleared on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      rf_q <= rf_d;
    end
  end

  // Operand reads with write-through bypass so a same-cycle writeback is seen.
  always_comb begin
    op_a_rd = '0;
    op_b_rd = '0;
    if (rs != '0) begin
      op_a_rd = (wb_en && (wb_addr == rs)) ? wb_data : rf_q[rs];
    end
    if (rt != '0) begin
      op_b_rd = (wb_en && (wb_addr == rt)) ? wb_data : rf_q[rt];
    end
  end

  // Decode control bits, destination and which register fields are sources.
  always_comb begin
    dec_dest      = '0;
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_branch    = 1'b0;
    uses_rs       = 1'b1;
    uses_rt       = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_dest      = rd;
        dec_reg_write = (rd != '0);
        uses_rt       = 1'b1;
        if ((funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA)) begin
          uses_rs = 1'b0;
        end
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        dec_dest      = rt;
        dec_reg_write = 1'b1;
      end
      OP_LW: begin
        dec_dest      = rt;
        dec_reg_write = 1'b1;
        dec_mem_read  = 1'b1;
      end
      OP_SW: begin
        dec_mem_write = 1'b1;
        uses_rt       = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec_branch = 1'b1;
        uses_rt    = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ID_ILLEGAL_TRAP_EN
  // Legal instruction set: the listed I-type opcodes plus 16 R-type functions.
  always_comb begin
    dec_legal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          6'b000000, 6'b000010, 6'b000011, 6'b000100,
          6'b000110, 6'b000111, 6'b100000, 6'b100001,
          6'b100010, 6'b100011, 6'b100100, 6'b100101,
          6'b100110, 6'b100111, 6'b101010, 6'b101011: dec_legal = 1'b1;
          default: ;
        endcase
      end
      OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LW, OP_SW: dec_legal = 1'b1;
      default: ;
    endcase
  end
`endif

  assign src_match = (uses_rs && (rs == out_dest_q)) || (uses_rt && (rt == out_dest_q));
  assign hazard    = out_valid_q && out_mem_read_q && (out_dest_q != '0) && in_valid && src_match;
  assign stall     = out_valid_q && !out_ready;
  assign in_ready  = rst_n && !stall && !hazard && !flush;

  // Output bundle next state: flush, then stall hold, then hazard bubble, then issue.
  always_comb begin
    out_valid_d     = out_valid_q;
    out_instr_d     = out_instr_q;
    out_op_a_d      = out_op_a_q;
    out_op_b_d      = out_op_b_q;
    out_dest_d      = out_dest_q;
    out_reg_write_d = out_reg_write_q;
    out_mem_read_d  = out_mem_read_q;
    out_mem_write_d = out_mem_write_q;
    out_branch_d    = out_branch_q;
`ifdef ID_ILLEGAL_TRAP_EN
    out_illegal_d   = out_illegal_q;
`endif
    if (flush || (!stall && !(in_valid && in_ready))) begin
      out_valid_d     = 1'b0;
      out_instr_d     = NOP_WORD;
      out_op_a_d      = '0;
      out_op_b_d      = '0;
      out_dest_d      = '0;
      out_reg_write_d = 1'b0;
      out_mem_read_d  = 1'b0;
      out_mem_write_d = 1'b0;
      out_branch_d    = 1'b0;
`ifdef ID_ILLEGAL_TRAP_EN
      if (flush) begin
        out_illegal_d = 1'b0;
      end
`endif
    end else if (!stall) begin
      out_valid_d     = 1'b1;
      out_instr_d     = in_instr;
      out_op_a_d      = op_a_rd;
      out_op_b_d      = op_b_rd;
      out_dest_d      = dec_dest;
      out_reg_write_d = dec_reg_write;
      out_mem_read_d  = dec_mem_read;
      out_mem_write_d = dec_mem_write;
      out_branch_d    = dec_branch;
`ifdef ID_ILLEGAL_TRAP_EN
      out_illegal_d   = !dec_legal;
      if (!dec_legal) begin
        out_instr_d     = NOP_WORD;
        out_op_a_d      = '0;
        out_op_b_d      = '0;
        out_dest_d      = '0;
        out_reg_write_d = 1'b0;
        out_mem_read_d  = 1'b0;
        out_mem_write_d = 1'b0;
        out_branch_d    = 1'b0;
      end
`endif
    end
  end

  // Output bundle register; reset discards any held bundle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q     <= 1'b0;
      out_instr_q     <= NOP_WORD;
      out_op_a_q      <= '0;
      out_op_b_q      <= '0;
      out_dest_q      <= '0;
      out_reg_write_q <= 1'b0;
      out_mem_read_q  <= 1'b0;
      out_mem_write_q <= 1'b0;
      out_branch_q    <= 1'b0;
`ifdef ID_ILLEGAL_TRAP_EN
      out_illegal_q   <= 1'b0;
`endif
    end else begin
      out_valid_q     <= out_valid_d;
      out_instr_q     <= out_instr_d;
      out_op_a_q      <= out_op_a_d;
      out_op_b_q      <= out_op_b_d;
      out_dest_q      <= out_dest_d;
      out_reg_write_q <= out_reg_write_d;
      out_mem_read_q  <= out_mem_read_d;
      out_mem_write_q <= out_mem_write_d;
      out_branch_q    <= out_branch_d;
`ifdef ID_ILLEGAL_TRAP_EN
      out_illegal_q   <= out_illegal_d;
`endif
    end
  end

  assign out_valid     = out_valid_q;
  assign out_instr     = out_instr_q;
  assign out_op_a      = out_op_a_q;
  assign out_op_b      = out_op_b_q;
  assign out_dest      = out_dest_q;
  assign out_reg_write = out_reg_write_q;
  assign out_mem_read  = out_mem_read_q;
  assign out_mem_write = out_mem_write_q;
  assign out_branch    = out_branch_q;
`ifdef ID_ILLEGAL_TRAP_EN
  assign out_illegal   = out_illegal_q;
`endif

endmodule
